// File: rtl/mem_bank_stream_fifo.sv
// Stream FIFO backed by an external single-port-per-direction registered RAM,
// with a 3-entry output buffer that absorbs the RAM read latency.
module mem_bank_stream_fifo #(
  parameter int AddressSz  = 7,
  parameter int data_width = 8,
  parameter int Sz         = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  mem_clk_en,
  output logic [data_width-1:0] mem_din,
  output logic [AddressSz-1:0]  mem_w_adr,
  output logic                  mem_w_en,
  output logic [AddressSz-1:0]  mem_r_adr,
  input  logic [data_width-1:0] mem_qout,
  output logic [AddressSz+1:0]  level
);

  localparam int CntW = AddressSz + 1;
  localparam int LvlW = AddressSz + 2;

  logic [AddressSz-1:0]  wr_ptr;
  logic [AddressSz-1:0]  rd_ptr;
  logic [CntW-1:0]       ram_cnt;
  logic                  rd_inflight;
  logic [1:0]            buf_cnt;
  logic [data_width-1:0] buf_q [3];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [1:0]            cap_idx;

  assign in_ready  = (ram_cnt < CntW'(Sz));
  assign push      = in_valid && in_ready && !rst;
  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_q[0];
  assign pop       = out_valid && out_ready;

  // A read is only launched when the buffer is guaranteed a free slot on return,
  // so a returning word never needs out_ready to be asserted.
  assign issue = !rst && (ram_cnt != '0) &&
                 ((3'(buf_cnt) + 3'(rd_inflight)) < 3'd3);

  assign mem_clk_en = 1'b1;
  assign mem_w_en   = push;
  assign mem_w_adr  = wr_ptr;
  assign mem_din    = in_data;
  assign mem_r_adr  = rd_ptr;

  assign level = LvlW'(ram_cnt) + LvlW'(rd_inflight) + LvlW'(buf_cnt);

  // Control state: pointers, RAM occupancy, read-return flag, buffer occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      rd_inflight <= issue;
      case ({rd_inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  assign cap_idx = buf_cnt - {1'b0, pop};

  // Output buffer data: shift on pop, returning RAM word lands at the new tail.
  always_ff @(posedge clk) begin
    if (pop) begin
      buf_q[0] <= buf_q[1];
      buf_q[1] <= buf_q[2];
    end
    for (int i = 0; i < 3; i++) begin
      if (rd_inflight && !rst && (cap_idx == 2'(i))) buf_q[i] <= mem_qout;
    end
  end

endmodule
